// File: rtl/block_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : block_stream_arbiter_if
// Purpose  : Source-side handshake and checker-side bus of block_stream_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface block_stream_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic [7:0]        chk_char;
    logic              chk_en;
    logic              chk_clr;
    logic              chk_result;

    // master: stream sources plus checker; slave: the arbiter
    modport master (
        output req, data, last, chk_result,
        input  ack, chk_char, chk_en, chk_clr
    );
    modport slave (
        input  req, data, last, chk_result,
        output ack, chk_char, chk_en, chk_clr
    );
endinterface
`default_nettype wire

// File: rtl/block_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : block_stream_arbiter
// Purpose  : Round-robin session arbiter sharing one nesting checker between
//            NREQ byte streams; optional STALL_TIMEOUT_EN aborts stalled owners.
// Revision : 1.0  initial release
// ============================================================================
module block_stream_arbiter #(
    parameter int NREQ    = 4,
    parameter int SRCW    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    block_stream_arbiter_if.slave bus,
    output logic [SRCW-1:0]       owner,
    output logic                  busy,
    output logic [NREQ-1:0]       verdict,
    output logic [NREQ-1:0]       verdict_valid
);

    if (SRCW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("block_stream_arbiter: illegal NREQ/SRCW/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SRCW-1:0] r_owner;
    logic [SRCW-1:0] r_rr_ptr;
    logic [NREQ-1:0] r_verdict;
    logic [NREQ-1:0] r_verdict_valid;
    logic [SRCW-1:0] w_sel;
    logic            w_found;
    logic [SRCW-1:0] w_next_ptr;
    logic            w_xfer;

`ifdef STALL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_stall_cnt;
    logic          w_abort;
`endif

    // First requester at or above the round-robin pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[(int'(r_rr_ptr) + i) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = SRCW'((int'(r_rr_ptr) + i) % NREQ);
            end
        end
    end

    assign w_next_ptr = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_next       = r_state;
        bus.ack      = '0;
        bus.chk_en   = 1'b0;
        bus.chk_clr  = 1'b0;
        bus.chk_char = bus.data[8*int'(r_owner) +: 8];
        w_xfer       = 1'b0;
`ifdef STALL_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_CLR;
            end
            S_CLR: begin
                bus.chk_clr = 1'b1;
                w_next      = S_STREAM;
            end
            S_STREAM: begin
                w_xfer           = bus.req[r_owner];
                bus.chk_en       = w_xfer;
                bus.ack[r_owner] = w_xfer;
                if (w_xfer && bus.last[r_owner]) begin
                    w_next = S_DONE;
                end
`ifdef STALL_TIMEOUT_EN
                else if (!w_xfer && r_stall_cnt == CW'(TIMEOUT - 1)) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Checker result is sampled in DONE, after its count has absorbed the last byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner         <= '0;
            r_rr_ptr        <= '0;
            r_verdict       <= '0;
            r_verdict_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_found) r_owner <= w_sel;
                S_CLR:  r_verdict_valid[r_owner] <= 1'b0;
                S_DONE: begin
                    r_verdict[r_owner]       <= bus.chk_result;
                    r_verdict_valid[r_owner] <= 1'b1;
                    r_rr_ptr                 <= w_next_ptr;
                end
                default: ;
            endcase
`ifdef STALL_TIMEOUT_EN
            if (w_abort) begin
                r_verdict[r_owner]       <= 1'b0;
                r_verdict_valid[r_owner] <= 1'b1;
                r_rr_ptr                 <= w_next_ptr;
            end
`endif
        end
    end

`ifdef STALL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      r_stall_cnt <= '0;
        else if (r_state != S_STREAM || w_xfer || w_abort) r_stall_cnt <= '0;
        else                                            r_stall_cnt <= r_stall_cnt + 1'b1;
    end
`endif

    assign owner         = r_owner;
    assign busy          = (r_state != S_IDLE);
    assign verdict       = r_verdict;
    assign verdict_valid = r_verdict_valid;

endmodule
`default_nettype wire

// File: tb/tb_block_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_stream_arbiter
// Purpose  : Directed table-driven bench for block_stream_arbiter with a
//            stand-in b/d nesting checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_block_stream_arbiter;
    localparam int NREQ = 4, SRCW = 2, TIMEOUT = 16, MAXLEN = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [SRCW-1:0] owner;
    logic            busy;
    logic [NREQ-1:0] verdict, verdict_valid;
    int              errors = 0, checks = 0;

    block_stream_arbiter_if #(.NREQ(NREQ)) bus();

    block_stream_arbiter #(.NREQ(NREQ), .SRCW(SRCW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .owner(owner), .busy(busy),
        .verdict(verdict), .verdict_valid(verdict_valid)
    );

    always #5 clk = ~clk;

    // Stand-in checker: 'b' opens, 'd' closes, closing below zero is an error
    int   depth;
    logic err;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= 0; err <= 1'b0;
        end else if (bus.chk_clr) begin
            depth <= 0; err <= 1'b0;
        end else if (bus.chk_en) begin
            if (bus.chk_char == "b") depth <= depth + 1;
            else if (bus.chk_char == "d") begin
                if (depth == 0) err <= 1'b1;
                else            depth <= depth - 1;
            end
        end
    end
    assign bus.chk_result = (depth == 0) && !err;

    typedef struct packed {
        int                  src;
        logic [8*MAXLEN-1:0] msg;
        int                  len;
        int                  stall_at;
        int                  stall_len;
        logic                exp_v;
    } sess_t;

    sess_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src(input sess_t s, input int pos, input bit in_stall, output logic [7:0] ch);
        bus.req  = '0;
        bus.data = '0;
        bus.last = in_stall ? '1 : '0;
        ch       = 8'h00;
        if (pos < s.len && !in_stall) begin
            ch                      = s.msg[8*(s.len-1-pos) +: 8];
            bus.req[s.src]          = 1'b1;
            bus.data[8*s.src +: 8]  = ch;
            bus.last[s.src]         = (pos == s.len - 1);
        end
    endtask

    task automatic run_session(input sess_t s);
        int pos = 0, stall_cnt = 0, edges = 0, acks = 0, clrs = 0;
        int bad_ack = 0, bad_byte = 0, bad_gap = 0;
        bit seen_busy = 0, in_stall = 0, was_clr = 0;
        logic snap_vv = verdict_valid[s.src];
        logic [7:0] ch;
        drive_src(s, pos, in_stall, ch);
        while (edges < 200) begin
            #1;
            if (bus.chk_clr) begin
                clrs++;
                check("vv_held_until_clr", 32'(verdict_valid[s.src]), 32'(snap_vv));
            end
            if (was_clr) check("vv_cleared_at_clr", 32'(verdict_valid[s.src]), 0);
            was_clr = bus.chk_clr;
            if ((bus.ack & ~(NREQ'(1) << s.src)) != 0) bad_ack++;
            if (in_stall && (bus.chk_en || bus.ack != 0)) bad_gap++;
            if (bus.ack[s.src]) begin
                if (clrs == 0 || !bus.chk_en || bus.chk_char != ch) bad_byte++;
                acks++;
                pos++;
            end else if (in_stall) begin
                stall_cnt++;
            end
            @(negedge clk);
            edges++;
            if (busy) seen_busy = 1;
            else if (seen_busy) break;
            in_stall = (s.stall_at > 0) && (pos == s.stall_at) && (stall_cnt < s.stall_len);
            drive_src(s, pos, in_stall, ch);
        end
        check("session_cycles", edges, s.len + 3 + s.stall_len);
        check("ack_count", acks, s.len);
        check("clr_pulses", clrs, 1);
        check("foreign_ack", bad_ack, 0);
        check("byte_path", bad_byte, 0);
        check("stall_gap", bad_gap, 0);
        check("owner", 32'(owner), s.src);
        check("verdict", 32'(verdict[s.src]), 32'(s.exp_v));
        check("verdict_valid", 32'(verdict_valid[s.src]), 1);
    endtask

    initial begin
        int   rr_pos [NREQ];
        int   rr_done[NREQ];
        int   allowed[NREQ];
        int   grants[$];
        int   exp_order[5];
        int   rr_bad, total, pos, gap;
        logic [7:0] ch;

        tbl[0] = '{src:0, msg:"begin end", len:9, stall_at:0, stall_len:0, exp_v:1'b1};
        tbl[1] = '{src:1, msg:"end begin", len:9, stall_at:0, stall_len:0, exp_v:1'b0};
        tbl[2] = '{src:1, msg:"bd",        len:2, stall_at:0, stall_len:0, exp_v:1'b1};
        tbl[3] = '{src:2, msg:"begin end", len:9, stall_at:3, stall_len:5, exp_v:1'b1};
        tbl[4] = '{src:3, msg:"b",         len:1, stall_at:0, stall_len:0, exp_v:1'b0};
        tbl[5] = '{src:3, msg:"x",         len:1, stall_at:0, stall_len:0, exp_v:1'b1};
        exp_order = '{0, 1, 2, 3, 0};
        allowed   = '{2, 1, 1, 1};

        reset = 1'b1; bus.req = '0; bus.data = '0; bus.last = '0;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_chk_en", 32'(bus.chk_en), 0);
        check("rst_chk_clr", 32'(bus.chk_clr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_verdict", 32'(verdict), 0);
        check("rst_verdict_valid", 32'(verdict_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_session(tbl[i]);

        // Round-robin with every source requesting; source 0 runs twice
        rr_bad = 0; total = 0;
        for (int i = 0; i < NREQ; i++) begin rr_pos[i] = 0; rr_done[i] = 0; end
        for (int cyc = 0; cyc < 100; cyc++) begin
            bus.req = '0; bus.data = '0; bus.last = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (rr_done[i] < allowed[i]) begin
                    bus.req[i]          = 1'b1;
                    bus.data[8*i +: 8]  = (rr_pos[i] == 0) ? 8'h62 : 8'h64;
                    bus.last[i]         = (rr_pos[i] == 1);
                end
            end
            #1;
            if (bus.chk_clr) grants.push_back(int'(owner));
            if ((bus.ack & ~(NREQ'(1) << owner)) != 0) rr_bad++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    if (rr_pos[i] == 1) begin rr_pos[i] = 0; rr_done[i]++; total++; end
                    else rr_pos[i]++;
                end
            end
            @(negedge clk);
            if (total == 5 && !busy) break;
        end
        bus.req = '0; bus.last = '0;
        check("rr_sessions", grants.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_grant%0d", k), (k < grants.size()) ? grants[k] : 99, exp_order[k]);
        check("rr_foreign_ack", rr_bad, 0);
        check("rr_verdict", 32'(verdict), 32'hF);
        check("rr_verdict_valid", 32'(verdict_valid), 32'hF);

        // Reset in the middle of a session after three bytes
        @(negedge clk);
        pos = 0;
        drive_src(tbl[3], pos, 1'b0, ch);
        for (int n = 0; n < 50 && pos < 3; n++) begin
            #1;
            if (bus.ack[2]) pos++;
            @(negedge clk);
            if (pos < 3) drive_src(tbl[3], pos, 1'b0, ch);
        end
        check("midrst_setup", pos, 3);
        reset = 1'b1;
        #1;
        check("midrst_ack", 32'(bus.ack), 0);
        check("midrst_chk_en", 32'(bus.chk_en), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_verdict", 32'(verdict), 0);
        check("midrst_verdict_valid", 32'(verdict_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 4'b1010; bus.last = 4'b1010; bus.data = {4{8'h78}};
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.chk_clr) begin gap = 1; break; end
            @(negedge clk);
        end
        check("postrst_clr_seen", gap, 1);
        check("postrst_owner", 32'(owner), 1);
        @(negedge clk);
        bus.req = 4'b0010;
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        bus.req = '0; bus.last = '0;
        check("postrst_idle", 32'(busy), 0);
        check("postrst_verdict_valid", 32'(verdict_valid), 32'b0010);
        check("postrst_verdict", 32'(verdict), 32'b0010);

`ifdef STALL_TIMEOUT_EN
        // Owner 0 sends one byte then goes silent; source 1 waits behind it
        @(negedge clk);
        bus.req = 4'b0001; bus.last = '0; bus.data = {4{8'h62}};
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.ack[0]) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.req = 4'b0010; bus.last = 4'b0010; bus.data = {4{8'h78}};
        gap = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (!busy) break;
            if (bus.ack == 0 && !bus.chk_clr) gap++;
            @(negedge clk);
        end
        check("to_stall_cycles", gap, TIMEOUT);
        check("to_verdict", 32'(verdict[0]), 0);
        check("to_verdict_valid", 32'(verdict_valid[0]), 1);
        @(negedge clk);
        #1;
        check("to_next_clr", 32'(bus.chk_clr), 1);
        check("to_next_owner", 32'(owner), 1);
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        bus.req = '0; bus.last = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/block_stream_arbiter.md
Name: block_stream_arbiter

Overview:
- Shares one begin/end nesting checker between NREQ character-stream sources.
- Grants one whole stream (session) at a time, round-robin.
- Pulses the checker's reset before each session and feeds bytes through a per-byte advance enable.
- Latches a per-source verdict from the checker's result when the session ends; sits between the stream sources and the checker instance.

Parameters:
- NREQ, 4, number of requesting sources (2..8).
- SRCW, 2, width of the source index; must equal ceil(log2(NREQ)).
- TIMEOUT, 16, idle-cycle limit used only with STALL_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  source i has a valid byte on data slice i
- data  input  8*NREQ  byte of source i on bits [8i+7:8i]
- last  input  NREQ  byte of source i is the final byte of its stream; qualified by req[i]
- ack  output  NREQ  byte of source i consumed at this clock edge
- chk_char  output  8  byte to the checker
- chk_en  output  1  checker advance enable; the checker consumes chk_char at the edge where chk_en=1
- chk_clr  output  1  synchronous clear to the checker, one cycle
- chk_result  input  1  checker result; 1 = nesting balanced
- owner  output  SRCW  index of the current or last granted source
- busy  output  1  a session is in progress (any state other than IDLE)
- verdict  output  NREQ  latched result per source
- verdict_valid  output  NREQ  verdict[i] holds a completed session result

Behaviour:
- Reset is clk, reset: asynchronous, active-high. Reset can occur at any time, including mid-session.
- Reset values: state=IDLE, rr_ptr=0, owner=0, verdict=0, verdict_valid=0. The combinational outputs ack, chk_en and chk_clr are therefore 0.
- States:
  - IDLE:
    - If req is nonzero, select the first set bit scanning upward from rr_ptr, wrapping modulo NREQ.
    - Register it as owner and go to CLR. No ack is given in IDLE.
  - CLR:
    - chk_clr=1 for exactly one cycle; chk_en=0.
    - verdict_valid[owner] is cleared at this edge. Go to STREAM.
  - STREAM:
    - chk_char = data slice owner.
    - chk_en = req[owner]; ack[owner] = req[owner]; all other ack bits are 0.
    - A transfer occurs at the edge where req[owner]=1.
    - If last[owner]=1 on a transfer, go to DONE.
    - req[owner]=0 stalls the session with no transfer and no checker advance; the grant is held.
  - DONE:
    - chk_en=0.
    - At this edge: verdict[owner]<=chk_result, verdict_valid[owner]<=1, rr_ptr<=(owner+1) mod NREQ. Go to IDLE.
- Timing rules:
  - chk_char, chk_en, ack and chk_clr are combinational from state/owner/req/data. There is no added latency on the data path.
  - chk_result is sampled in DONE, one cycle after the final byte edge, so the checker's registered count has settled.
- Overhead: 3 cycles per session (IDLE, CLR, DONE) plus one cycle per byte.
- Boundary conditions:
  - A one-byte stream (req and last together in the first STREAM cycle) is legal.
  - last without req is ignored.
  - Requests from non-owners are never acked and wait for IDLE.
  - When rr_ptr=NREQ-1, the next rr_ptr wraps to 0.
  - A sole requester that re-requests immediately is re-granted; its old verdict_valid stays 1 until its next CLR.
  - Reset mid-STREAM aborts the session with no verdict update (all verdicts clear).
  - The checker receives no chk_clr on reset; it shares the global reset.

Optional Feature:
- Macro: STALL_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive STREAM cycles with req[owner]=0 and clears on any transfer.
  - When it reaches TIMEOUT, the session is aborted: verdict[owner]<=0, verdict_valid[owner]<=1, rr_ptr advances, next state is IDLE.
  - There is no DONE cycle and no checker sampling.
- Not defined: no counter exists; a stalled owner holds the grant indefinitely.

Test Plan:
- Single stream: src0 sends "begin end" (9 bytes, last on 'd'); checker balanced.
  - Response: the CLR pulse precedes the first ack; 9 acks; chk_result=1 sampled in DONE; verdict[0]=1, verdict_valid[0]=1; busy deasserts 12 cycles after grant.
- Unbalanced stream: src1 sends "end begin".
  - Response: verdict[1]=0 and verdict_valid[1]=1, with chk_result sampled in DONE.
- Round-robin: req=4'b1111 held, each source sends 2 bytes.
  - Response: grant order 0,1,2,3,0; no ack to a non-owner; each session is bracketed by a chk_clr pulse.
- Stall mid-stream: src2 drops req for 5 cycles after "beg".
  - Response: chk_en=0 during the gap; the grant is held; the final verdict equals the unstalled result.
- Reset mid-STREAM after 3 bytes.
  - Response: ack, chk_en and busy go to 0 immediately; all verdict and verdict_valid bits are 0; the next grant goes to the lowest requester from index 0.
- STALL_TIMEOUT_EN with TIMEOUT=16: owner idles 16 cycles.
  - Response: abort with verdict=0, verdict_valid=1; the next requester is granted on the following IDLE cycle.
